// File: rtl/sparc_windowed_regfile_pkg.sv
// Shared constants, types and helpers for the windowed SPARC register file.
package sparc_windowed_regfile_pkg;

  localparam int NGLOBAL  = 8;
  localparam int WINSIZE  = 16;
  localparam int NWIN_DEF = 4;
  localparam int NPHYS    = NGLOBAL + WINSIZE * NWIN_DEF;
  localparam int PIDX_W   = 7;
  localparam int CWP_W    = 2;

  // Logical register groups, encoded as the top two bits of the logical address.
  typedef enum logic [1:0] {
    REG_GLOBAL = 2'b00,
    REG_OUT    = 2'b01,
    REG_LOCAL  = 2'b10,
    REG_IN     = 2'b11
  } reg_region_t;

  typedef struct packed {
    logic [4:0] idx;
    logic       valid;
    logic       multi;
  } onehot_info_t;

  // Classifies a select vector: valid = exactly one bit set, multi = two or more.
  // idx is the position of the highest set bit (meaningful only when valid).
  function automatic onehot_info_t onehot_check(input logic [31:0] vec);
    onehot_info_t info;
    int unsigned  cnt;
    info = '0;
    cnt  = 0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) begin
        cnt      = cnt + 1;
        info.idx = 5'(i);
      end
    end
    info.valid = (cnt == 1);
    info.multi = (cnt > 1);
    return info;
  endfunction

endpackage

// File: rtl/sparc_windowed_regfile_if.sv
// Bus bundle between the decoder glue logic and the windowed register file.
interface sparc_windowed_regfile_if
  import sparc_windowed_regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NWIN  = NWIN_DEF
);
  logic [31:0]      WeSel;
  logic [WIDTH-1:0] WrData;
  logic [NWIN-1:0]  WinSel;
  logic [4:0]       RdAddrA;
  logic [4:0]       RdAddrB;
  logic [WIDTH-1:0] RdDataA;
  logic [WIDTH-1:0] RdDataB;
  logic [CWP_W-1:0] Cwp;
  logic             SelErr;

  modport master (
    output WeSel, WrData, WinSel, RdAddrA, RdAddrB,
    input  RdDataA, RdDataB, Cwp, SelErr
  );

  modport slave (
    input  WeSel, WrData, WinSel, RdAddrA, RdAddrB,
    output RdDataA, RdDataB, Cwp, SelErr
  );
endinterface

// File: rtl/sparc_windowed_regfile_window.sv
// Logical-to-physical register index translation for one access port.
// Ins of window w are the outs of window w+1 (wrapping), so the two
// names resolve to the same physical word.
module sparc_window_map
  import sparc_windowed_regfile_pkg::*;
#(
  parameter int NWIN = NWIN_DEF
) (
  input  logic [4:0]        log_addr,
  input  logic [CWP_W-1:0]  cwp,
  output logic [PIDX_W-1:0] phys_idx
);

  reg_region_t      region;
  logic [2:0]       offs;
  logic [CWP_W-1:0] next_win;

  // Select the register group and add the window base for that group.
  always_comb begin
    region   = reg_region_t'(log_addr[4:3]);
    offs     = log_addr[2:0];
    next_win = (int'(cwp) == NWIN - 1) ? '0 : cwp + 1'b1;
    phys_idx = PIDX_W'(offs);
    case (region)
      REG_GLOBAL: phys_idx = PIDX_W'(offs);
      REG_OUT:    phys_idx = PIDX_W'(NGLOBAL + WINSIZE * int'(cwp) + int'(offs));
      REG_LOCAL:  phys_idx = PIDX_W'(NGLOBAL + 8 + WINSIZE * int'(cwp) + int'(offs));
      REG_IN:     phys_idx = PIDX_W'(NGLOBAL + WINSIZE * int'(next_win) + int'(offs));
      default:    phys_idx = PIDX_W'(offs);
    endcase
  end

endmodule

// File: rtl/sparc_windowed_regfile.sv
// Windowed SPARC integer register file: 8 globals plus NWIN overlapping
// windows of 16, two combinational read ports, one synchronous write port.
// The selects arrive one-hot from upstream decoders; malformed selects are
// ignored and latched into a sticky error flag. Cwp is 2 bits wide, so NWIN
// is expected to stay at 4.
module sparc_windowed_regfile
  import sparc_windowed_regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NWIN  = NWIN_DEF
) (
  input  logic                    Clk,
  input  logic                    Reset,
  sparc_windowed_regfile_if.slave bus
);

  localparam int NPHYS_L = NGLOBAL + WINSIZE * NWIN;

  logic [WIDTH-1:0]  regs_q [NPHYS_L];
  logic [WIDTH-1:0]  regs_d [NPHYS_L];
  logic [CWP_W-1:0]  cwp_q, cwp_d;
  logic              sel_err_q, sel_err_d;

  onehot_info_t      we_info, win_info;
  logic [PIDX_W-1:0] wr_phys, rd_phys_a, rd_phys_b;

  sparc_window_map #(.NWIN(NWIN)) u_map_wr (
    .log_addr (we_info.idx),
    .cwp      (cwp_q),
    .phys_idx (wr_phys)
  );

  sparc_window_map #(.NWIN(NWIN)) u_map_rd_a (
    .log_addr (bus.RdAddrA),
    .cwp      (cwp_q),
    .phys_idx (rd_phys_a)
  );

  sparc_window_map #(.NWIN(NWIN)) u_map_rd_b (
    .log_addr (bus.RdAddrB),
    .cwp      (cwp_q),
    .phys_idx (rd_phys_b)
  );

  // Validate selects, then compute next storage, window pointer and error flag.
  // The write is mapped through the current cwp_q, so a simultaneous window
  // change only affects later accesses.
  always_comb begin
    we_info   = onehot_check(bus.WeSel);
    win_info  = onehot_check(32'(bus.WinSel));
    regs_d    = regs_q;
    cwp_d     = cwp_q;
    sel_err_d = sel_err_q;
    if (we_info.valid && (we_info.idx != 5'd0)) begin
      regs_d[wr_phys] = bus.WrData;
    end
    if (win_info.valid) begin
      cwp_d = CWP_W'(win_info.idx);
    end
    if (we_info.multi || win_info.multi) begin
      sel_err_d = 1'b1;
    end
  end

  // State registers; synchronous reset overrides any pending write or window change.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs_q    <= '{default: '0};
      cwp_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      cwp_q     <= cwp_d;
      sel_err_q <= sel_err_d;
    end
  end

  // r0 reads zero regardless of storage contents.
  assign bus.RdDataA = (bus.RdAddrA == 5'd0) ? '0 : regs_q[rd_phys_a];
  assign bus.RdDataB = (bus.RdAddrB == 5'd0) ? '0 : regs_q[rd_phys_b];
  assign bus.Cwp     = cwp_q;
  assign bus.SelErr  = sel_err_q;

endmodule

// File: doc/sparc_windowed_regfile.md
# sparc_windowed_regfile

Windowed SPARC integer register file that consumes the one-hot outputs of the glue-logic decoders: the 32-bit write-select from the 5x32 decoder and the 4-bit window-select from the 2x4 decoder. It holds 8 globals plus 4 overlapping windows of 16 registers, 72 physical words in total. It provides two combinational read ports and one synchronous write port, and sits directly downstream of the decoders in the datapath.

## Interface
- `WIDTH`, 32: data word width.
- `NWIN`, 4: number of register windows; must equal the width of `WinSel`.
- `Clk` in 1: single clock, all state updates on rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `WeSel` in 32: one-hot logical write-register select (5x32 decoder output); all-zero means no write.
- `WrData` in WIDTH: write data.
- `WinSel` in NWIN: one-hot window select (2x4 decoder output); all-zero means hold the current window.
- `RdAddrA` in 5: logical read address, port A.
- `RdAddrB` in 5: logical read address, port B.
- `RdDataA` out WIDTH: port A read data.
- `RdDataB` out WIDTH: port B read data.
- `Cwp` out 2: current window pointer (registered).
- `SelErr` out 1: sticky error flag, set on a malformed `WeSel` or `WinSel`.

## Operation
- Logical-to-physical mapping for window w:
  - r0-r7 (globals) → phys 0-7.
  - r8-r15 (outs) → 8+16w+(r-8).
  - r16-r23 (locals) → 16+16w+(r-16).
  - r24-r31 (ins) → outs of window (w+1) mod NWIN, i.e. 8+16((w+1) mod NWIN)+(r-24).
- Window 3 ins alias window 0 outs (wrap-around).
- r0 reads 0 always. Writes to r0 are discarded with no error.
- Write rules:
  - `WeSel` exactly one-hot: write `WrData` at the edge to the physical register mapped through the current `Cwp`.
  - `WeSel` all-zero: no write.
  - `WeSel` with ≥2 bits set: no write; `SelErr` set.
- Window rules:
  - `WinSel` exactly one-hot: `Cwp` loads the encoded index at the edge.
  - `WinSel` all-zero: `Cwp` holds.
  - `WinSel` with ≥2 bits set: `Cwp` holds; `SelErr` set.
- `SelErr` clears only on `Reset`.
- Reads are combinational: storage is indexed through the current `Cwp` and `RdAddrA` / `RdAddrB`.

## Timing
- Reset (synchronous, takes priority over everything): all 72 registers = 0, `Cwp` = 0, `SelErr` = 0; `RdDataA` = `RdDataB` = 0 from the next cycle.
- Reset asserted mid-operation: any write or window change in that cycle is dropped.
- Write latency: data is visible on the read ports in the cycle after the write edge. There is no same-cycle bypass; a read of the written register during the write cycle returns the old value.
- Window change latency: the new `Cwp` affects mapping from the cycle after the edge.
- Write and window change in the same cycle: the write uses the old `Cwp`; the new window applies afterwards.
- Both read ports may address the same register, or an aliased in/out pair; both return the identical physical word.

## Structure
- Shared package holds:
  - Constants: NGLOBAL=8, WINSIZE=16, NPHYS=8+16·NWIN (=72).
  - Function `onehot_check`, returning the index plus valid and multi flags.
- One sub-module, `sparc_window_map`: combinational (5-bit logical address, 2-bit `Cwp`) → 7-bit physical index.
  - Instanced three times: write port, read port A, read port B.
- Top level holds the storage array, the `Cwp` register, the `SelErr` register and the one-hot validation.

## Test plan
- Reset, then read all 32 logical registers in each window → all read 0; `Cwp`=0; `SelErr`=0.
- Window 0, `WeSel`=1<<8, `WrData`=32'hA5A5_0008; then `WinSel`=4'b1000 (window 3) and read r24 → 32'hA5A5_0008 (wrap alias).
- `WeSel`=1<<0, `WrData`=32'hFFFF_FFFF → r0 still reads 0, `SelErr`=0.
- Write r16=32'h1111_1111 in window 1, switch to window 2, read r16 → 0; switch back to window 1 → 32'h1111_1111.
- `WeSel`=32'h0000_0300 → no register changes; `SelErr`=1 and stays 1 until `Reset`.
- Same cycle: `WinSel`=4'b0100 with a write to r9=32'hDEAD_BEEF → the value lands in window 0 outs, not window 2; `Cwp`=2 next cycle; assert `Reset` on a write cycle → the write is dropped.
